// File: rtl/md_ctrl.sv
// ============================================================================
//  Module      : md_ctrl
//  Description : E-stage multiply/divide sequencer owning HI/LO, with fixed
//                latency countdown, hazard stall request and drop detection.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    output logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        err_drop
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1) + 1;

    localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]         r_hi, w_hi_nxt;
    logic [31:0]         r_lo, w_lo_nxt;
    logic [31:0]         r_hi_t, w_hi_t_nxt;
    logic [31:0]         r_lo_t, w_lo_t_nxt;
    logic                r_dz, w_dz_nxt;
    logic                r_err_drop, w_err_nxt;

    logic        w_is_mult, w_is_div, w_any_op;
    logic        w_div_zero, w_div_ovf;
    logic [31:0] w_divisor_s, w_divisor_u;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_quot_s, w_rem_s;
    logic [31:0]        w_quot_u, w_rem_u;
    logic [31:0]        w_res_hi, w_res_lo;

    assign w_is_mult = (E_MDOp == c_OP_MULT) || (E_MDOp == c_OP_MULTU);
    assign w_is_div  = (E_MDOp == c_OP_DIV)  || (E_MDOp == c_OP_DIVU);
    assign start     = w_is_mult | w_is_div;
    assign w_any_op  = start | (E_MDOp == c_OP_MTHI) | (E_MDOp == c_OP_MTLO);

    assign busy     = (r_state == S_RUN);
    assign md_stall = D_md_use & (start | busy);
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign err_drop = r_err_drop;

    // Substituting a divisor of 1 keeps the dividers well-defined; for the
    // signed overflow case it also yields exactly quotient=0x80000000, rem=0.
    assign w_div_zero  = (E_B == 32'd0);
    assign w_div_ovf   = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
    assign w_divisor_s = (w_div_zero || w_div_ovf) ? 32'd1 : E_B;
    assign w_divisor_u = w_div_zero ? 32'd1 : E_B;

    assign w_prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};
    assign w_quot_s = $signed(E_A) / $signed(w_divisor_s);
    assign w_rem_s  = $signed(E_A) % $signed(w_divisor_s);
    assign w_quot_u = E_A / w_divisor_u;
    assign w_rem_u  = E_A % w_divisor_u;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (E_MDOp)
            c_OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            c_OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            c_OP_DIV: begin
                w_res_hi = w_rem_s;
                w_res_lo = w_quot_s;
            end
            c_OP_DIVU: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quot_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_hi_t     <= 32'd0;
            r_lo_t     <= 32'd0;
            r_dz       <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_hi_t     <= w_hi_t_nxt;
            r_lo_t     <= w_lo_t_nxt;
            r_dz       <= w_dz_nxt;
            r_err_drop <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_hi_t_nxt  = r_hi_t;
        w_lo_t_nxt  = r_lo_t;
        w_dz_nxt    = r_dz;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = w_is_mult ? c_MULT_CNT : c_DIV_CNT;
                    w_hi_t_nxt  = w_res_hi;
                    w_lo_t_nxt  = w_res_lo;
                    w_dz_nxt    = w_is_div & w_div_zero;
                end else if (E_MDOp == c_OP_MTHI) begin
                    w_hi_nxt = E_A;
                end else if (E_MDOp == c_OP_MTLO) begin
                    w_lo_nxt = E_A;
                end
            end
            S_RUN: begin
                // Anything arriving while running is discarded and flagged.
                w_err_nxt = w_any_op;
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_state_nxt = S_IDLE;
                    if (!r_dz) begin
                        w_hi_nxt = r_hi_t;
                        w_lo_nxt = r_lo_t;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_md_ctrl.sv
// ============================================================================
//  Module      : tb_md_ctrl
//  Description : Directed and randomized self-checking bench for md_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  E_MDOp;
    logic [31:0] E_A, E_B;
    logic        D_md_use;
    logic        start, busy, md_stall, err_drop;
    logic [31:0] HI, LO;

    md_ctrl #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B),
        .D_md_use(D_md_use), .start(start), .busy(busy), .md_stall(md_stall),
        .HI(HI), .LO(LO), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    // Reference model: architectural HI/LO, cycles left, pending result
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;
    bit          m_pdz, m_err;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic rst);
        logic [63:0] p;
        longint      sa, sb, q, r;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_pdz = 0; m_err = 0;
            return;
        end
        m_err = 0;
        if (m_left > 0) begin
            if (op >= 1 && op <= 6) m_err = 1;
            m_left--;
            if (m_left == 0 && !m_pdz) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (op >= 1 && op <= 4) begin
            m_pdz = 0;
            if (op == 1) begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_phi = p[63:32]; m_plo = p[31:0];
            end else if (op == 2) begin
                p = {32'd0, a} * {32'd0, b};
                m_phi = p[63:32]; m_plo = p[31:0];
            end else if (b == 0) begin
                m_pdz = 1;
            end else if (op == 3) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q = sa / sb;
                r = sa % sb;
                m_plo = q[31:0]; m_phi = r[31:0];
            end else begin
                m_plo = a / b; m_phi = a % b;
            end
            m_left = (op <= 2) ? MULT_CYC : DIV_CYC;
        end else if (op == 5) begin
            m_hi = a;
        end else if (op == 6) begin
            m_lo = a;
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check state.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic rst);
        logic exp_start;
        reset = rst; E_MDOp = op; E_A = a; E_B = b; D_md_use = use_d;
        #1;
        exp_start = (op >= 1 && op <= 4);
        chk("start", 32'(start), 32'(exp_start));
        chk("md_stall", 32'(md_stall), 32'(use_d && (exp_start || m_left > 0)));
        if (md_stall === 1'b1) stall_cnt++;
        @(posedge clk);
        model_edge(op, a, b, rst);
        #1;
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("err_drop", 32'(err_drop), 32'(m_err));
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
    endtask

    task automatic wait_idle(input logic use_d, output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step(3'd0, 32'd0, 32'd0, use_d, 1'b0);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [2:0] op;
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_pdz = 0; m_err = 0;
        reset = 1'b1; E_MDOp = 3'd0; E_A = 0; E_B = 0; D_md_use = 1'b0;
        #2;
        step(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_err", 32'(err_drop), 32'd0);

        // Signed multiply -3 * 5
        step(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        wait_idle(1'b0, n);
        chk("mult_busy_len", 32'(n), 32'd5);
        chk("mult_HI", HI, 32'hFFFF_FFFF);
        chk("mult_LO", LO, 32'hFFFF_FFF1);

        // Unsigned divide 7 / 2
        step(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        wait_idle(1'b0, n);
        chk("divu_busy_len", 32'(n), 32'd10);
        chk("divu_LO", LO, 32'd3);
        chk("divu_HI", HI, 32'd1);

        // Signed divide -7 / 2
        step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        wait_idle(1'b0, n);
        chk("div_LO", LO, 32'hFFFF_FFFD);
        chk("div_HI", HI, 32'hFFFF_FFFF);

        // mthi with D_md_use held: no latency, no busy, no stall
        step(3'd5, 32'h0000_ABCD, 32'd0, 1'b1, 1'b0);
        chk("mthi_HI", HI, 32'h0000_ABCD);
        chk("mthi_busy", 32'(busy), 32'd0);

        // Divide by zero keeps preloaded HI/LO
        step(3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        step(3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        step(3'd3, 32'd1234, 32'd0, 1'b0, 1'b0);
        wait_idle(1'b0, n);
        chk("dz_busy_len", 32'(n), 32'd10);
        chk("dz_HI", HI, 32'h11);
        chk("dz_LO", LO, 32'h22);

        // Signed overflow
        step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_idle(1'b0, n);
        chk("ovf_LO", LO, 32'h8000_0000);
        chk("ovf_HI", HI, 32'd0);

        // Stall window: start cycle plus every busy cycle
        stall_cnt = 0;
        step(3'd1, 32'd3, 32'd4, 1'b1, 1'b0);
        wait_idle(1'b1, n);
        step(3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("stall_len", 32'(stall_cnt), 32'd6);

        // Reset at busy cycle 4 of a divide
        step(3'd4, 32'd100, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 12; i++) step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("midrst_HI", HI, 32'd0);
        chk("midrst_LO", LO, 32'd0);

        // Op injected while busy is dropped
        step(3'd1, 32'd6, 32'd7, 1'b0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(3'd1, 32'd100, 32'd100, 1'b0, 1'b0);
        chk("drop_pulse", 32'(err_drop), 32'd1);
        step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("drop_pulse_end", 32'(err_drop), 32'd0);
        wait_idle(1'b0, n);
        chk("drop_LO", LO, 32'd42);
        chk("drop_HI", HI, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (m_left > 0)
                op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
            else
                op = 3'($urandom_range(0, 7));
            step(op, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 79) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer for the E stage of the five-stage MIPS pipeline.
- Owns the HI/LO registers and the busy countdown. Those HI/LO values travel down the pipeline to M and W for mfhi/mflo.
- Accepts mult/multu/div/divu/mthi/mtlo from E and models fixed-latency execution.
- Raises a stall request to the hazard unit when a HI/LO-using instruction in D would observe an in-flight result.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start (>=1)
DIV_CYCLES, 10, busy cycles after a div/divu start (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
E_MDOp  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
E_A  input  32  forwarded rs value
E_B  input  32  forwarded rt value
D_md_use  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
start  output  1  combinational: E_MDOp in 1..4
busy  output  1  registered: operation in flight
md_stall  output  1  combinational: D_md_use & (start | busy)
HI  output  32  architectural HI register
LO  output  32  architectural LO register
err_drop  output  1  registered one-cycle pulse: an op was ignored because busy

Behaviour:
- Reset values:
  - HI=0, LO=0, busy=0, err_drop=0.
  - Internal counter=0; pending HI/LO temporaries=0.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter>0).
- IDLE + start at edge k:
  - Latch the computed result into temporaries hi_t/lo_t.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - busy=1 from cycle k+1.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter goes 1->0: HI<=hi_t, LO<=lo_t, busy<=0.
  - busy is high for exactly MULT_CYCLES/DIV_CYCLES cycles; new HI/LO are visible in the same cycle busy falls.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product of E_A, E_B.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Overflow (0x80000000 / 0xFFFFFFFF signed): LO=0x80000000, HI=0.
  - Divide by zero (E_B=0, ops 3/4): sequence runs normally (busy for DIV_CYCLES), but on completion HI/LO keep their previous values.
- mthi/mtlo in IDLE: HI<=E_A (op 5) or LO<=E_A (op 6) at the next edge; busy stays 0; no latency.
- Any op 1..6 arriving while busy=1:
  - The hazard protocol prevents this; if it occurs anyway, the op is ignored.
  - In-flight state is unaffected.
  - err_drop pulses 1 for one cycle after that edge.
- md_stall:
  - Asserted in the start cycle and every busy cycle whenever D_md_use=1.
  - Deasserts in the cycle busy falls, so a following mfhi in D reads the new HI via the M/W pipeline.
- Reset mid-operation: next edge forces IDLE, counter=0, busy=0, HI=LO=0; the pending result is discarded.
- Simultaneous completion edge and new start: cannot be accepted (busy=1 at that edge), so it is dropped per the rule above. The stall protocol prevents this case.
- Width rules:
  - Products are computed at 64 bits with explicit signed/unsigned casting.
  - No result truncation other than the HI/LO split.

Test Plan:
- Signed mult: reset; E_MDOp=1, E_A=0xFFFFFFFD (-3), E_B=5 for one cycle -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Unsigned divide: E_MDOp=4, E_A=7, E_B=2 -> busy 10 cycles; then LO=3, HI=1.
- Signed divide: E_MDOp=3, E_A=0xFFFFFFF9 (-7), E_B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Edge cases:
  - Divide by zero with preloaded HI=0x11, LO=0x22 -> busy 10 cycles; HI/LO unchanged.
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Stall and moves:
  - D_md_use=1 held during a mult -> md_stall high in the start cycle plus 5 busy cycles, low afterwards.
  - mthi E_A=0xABCD in IDLE -> HI=0xABCD next cycle, busy stays 0, md_stall=0.
- Reset and dropped ops:
  - Assert reset at busy cycle 4 of a div -> next cycle busy=0, HI=LO=0, no late write.
  - Inject mult while busy -> err_drop pulses once; the original result is written unchanged.
